// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates COUNT unsigned DATAWIDTH-bit beats into one total
// with a sticky carry-out flag, then holds the result until the sink takes it.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Din/InValid/InReady   input beat handshake (InReady is combinational)
//   Clear             drop the partial accumulation (ignored while a result is held)
//   Acc/Ovf           registered result and wrap flag
//   OutValid/OutReady     result handshake
module sum_accumulator #(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned COUNT     = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] Din,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Clear,
  output logic [DATAWIDTH-1:0] Acc,
  output logic                 Ovf,
  output logic                 OutValid,
  input  logic                 OutReady
);

  localparam int unsigned CNTW = $clog2(COUNT + 1);
  localparam int unsigned SUMW = DATAWIDTH + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] acc_int_q, acc_int_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 ovf_int_q, ovf_int_d;
  logic [DATAWIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 in_ready;
  logic                 accept;
  logic                 last_beat;
  logic [SUMW-1:0]      sum;

  // Handshake qualifiers and the carry-extended running sum
  always_comb begin
    in_ready  = (state_q == ACCUM) && !Clear;
    accept    = InValid && in_ready;
    sum       = SUMW'(acc_int_q) + SUMW'(Din);
    last_beat = accept && (cnt_q == CNTW'(COUNT - 1));
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    acc_int_d   = acc_int_q;
    cnt_d       = cnt_q;
    ovf_int_d   = ovf_int_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ACCUM: begin
        if (Clear) begin
          acc_int_d = '0;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end else if (last_beat) begin
          // Final beat goes straight into the output registers
          acc_d       = sum[DATAWIDTH-1:0];
          ovf_d       = ovf_int_q | sum[DATAWIDTH];
          out_valid_d = 1'b1;
          acc_int_d   = '0;
          cnt_d       = '0;
          ovf_int_d   = 1'b0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_int_d = sum[DATAWIDTH-1:0];
          ovf_int_d = ovf_int_q | sum[DATAWIDTH];
          cnt_d     = cnt_q + CNTW'(1);
        end
      end
      HOLD: begin
        // Acc/Ovf are left untouched after the handshake
        if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ACCUM;
      acc_int_q   <= '0;
      cnt_q       <= '0;
      ovf_int_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_int_q   <= acc_int_d;
      cnt_q       <= cnt_d;
      ovf_int_q   <= ovf_int_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady  = in_ready;
  assign Acc      = acc_q;
  assign Ovf      = ovf_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator: two instances (COUNT=4 and COUNT=1, DATAWIDTH=8)
// share one directed stimulus stream; each is compared every cycle against a
// block-sum model, and key results are also pinned to literal values.
module tb_sum_accumulator;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Din = '0;
  logic       InValid = 1'b0;
  logic       Clear = 1'b0;
  logic       OutReady = 1'b0;

  logic       in_ready0, in_ready1;
  logic [7:0] acc0, acc1;
  logic       ovf0, ovf1;
  logic       out_valid0, out_valid1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sum_accumulator #(.DATAWIDTH(8), .COUNT(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Din(Din), .InValid(InValid), .InReady(in_ready0),
    .Clear(Clear), .Acc(acc0), .Ovf(ovf0), .OutValid(out_valid0), .OutReady(OutReady)
  );

  sum_accumulator #(.DATAWIDTH(8), .COUNT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Din(Din), .InValid(InValid), .InReady(in_ready1),
    .Clear(Clear), .Acc(acc1), .Ovf(ovf1), .OutValid(out_valid1), .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Block-level model: sum beats as plain integers; a result wrapped if the
  // unbounded total reached 256.
  int m_sum  [2] = '{0, 0};
  int m_n    [2] = '{0, 0};
  int m_acc  [2] = '{0, 0};
  bit m_ovf  [2] = '{0, 0};
  bit m_pend [2] = '{0, 0};
  int m_blk  [2] = '{4, 1};

  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        m_sum[k] = 0; m_n[k] = 0; m_acc[k] = 0; m_ovf[k] = 0; m_pend[k] = 0;
      end else if (m_pend[k]) begin
        if (OutReady) m_pend[k] = 0;
      end else if (Clear) begin
        m_sum[k] = 0; m_n[k] = 0;
      end else if (InValid) begin
        m_sum[k] += int'(Din);
        m_n[k]++;
        if (m_n[k] == m_blk[k]) begin
          m_acc[k]  = m_sum[k] % 256;
          m_ovf[k]  = (m_sum[k] >= 256);
          m_pend[k] = 1;
          m_sum[k]  = 0;
          m_n[k]    = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("c4_out_valid", 32'(out_valid0), 32'(m_pend[0]));
      chk("c4_acc",       32'(acc0),       32'(m_acc[0]));
      chk("c4_ovf",       32'(ovf0),       32'(m_ovf[0]));
      chk("c4_in_ready",  32'(in_ready0),  32'(!m_pend[0] && !Clear));
      chk("c1_out_valid", 32'(out_valid1), 32'(m_pend[1]));
      chk("c1_acc",       32'(acc1),       32'(m_acc[1]));
      chk("c1_ovf",       32'(ovf1),       32'(m_ovf[1]));
      chk("c1_in_ready",  32'(in_ready1),  32'(!m_pend[1] && !Clear));
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge
  task automatic cyc(input logic rst, input logic v, input logic [7:0] d,
                     input logic clr, input logic ordy);
    Rst = rst; InValid = v; Din = d; Clear = clr; OutReady = ordy;
    @(posedge Clk);
    #1;
  endtask

  task automatic block4(input logic [7:0] a, b, c, d, input logic ordy);
    cyc(0, 1, a, 0, ordy);
    cyc(0, 1, b, 0, ordy);
    cyc(0, 1, c, 0, ordy);
    cyc(0, 1, d, 0, ordy);
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 0, 8'd0, 0, ordy);
  endtask

  initial begin
    // Reset with random inputs
    #1;
    cyc(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    cmp_en = 1'b1;
    cyc(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    Rst = 0; InValid = 0; Clear = 0; OutReady = 1;
    #1;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_acc",       32'(acc0),       32'd0);
    chk("rst_ovf",       32'(ovf0),       32'd0);
    chk("rst_in_ready",  32'(in_ready0),  32'd1);

    // Back-to-back 1,2,3,4
    block4(8'd1, 8'd2, 8'd3, 8'd4, 1);
    chk("b2b_valid",    32'(out_valid0), 32'd1);
    chk("b2b_acc",      32'(acc0),       32'd10);
    chk("b2b_ovf",      32'(ovf0),       32'd0);
    chk("b2b_hold_rdy", 32'(in_ready0),  32'd0);
    idle(1);
    chk("b2b_drained",  32'(out_valid0), 32'd0);
    chk("b2b_rdy_back", 32'(in_ready0),  32'd1);
    chk("b2b_acc_kept", 32'(acc0),       32'd10);

    // Overflow then clean block
    block4(8'd200, 8'd100, 8'd0, 8'd0, 1);
    chk("ovf_acc", 32'(acc0), 32'd44);
    chk("ovf_ovf", 32'(ovf0), 32'd1);
    idle(1);
    block4(8'd1, 8'd1, 8'd1, 8'd1, 1);
    chk("post_ovf_acc", 32'(acc0), 32'd4);
    chk("post_ovf_ovf", 32'(ovf0), 32'd0);
    idle(1);

    // Backpressure: result held, offered beats ignored
    block4(8'd1, 8'd2, 8'd3, 8'd4, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'd99, 0, 0);
      chk("bp_valid", 32'(out_valid0), 32'd1);
      chk("bp_acc",   32'(acc0),       32'd10);
      chk("bp_rdy",   32'(in_ready0),  32'd0);
    end
    cyc(0, 1, 8'd99, 0, 1);
    chk("bp_release", 32'(out_valid0), 32'd0);

    // Gapped beats
    cyc(0, 1, 8'd1, 0, 1); idle(1);
    cyc(0, 1, 8'd2, 0, 1); idle(1); idle(1);
    cyc(0, 1, 8'd3, 0, 1);
    cyc(0, 1, 8'd4, 0, 1);
    chk("gap_acc", 32'(acc0), 32'd10);
    idle(1);

    // Clear mid-block, beat 9 offered alongside Clear
    cyc(0, 1, 8'd5, 0, 1);
    cyc(0, 1, 8'd6, 0, 1);
    Clear = 1; InValid = 1; Din = 8'd9; #1;
    chk("clr_rdy", 32'(in_ready0), 32'd0);
    cyc(0, 1, 8'd9, 1, 1);
    block4(8'd1, 8'd1, 8'd1, 8'd1, 1);
    chk("clr_acc", 32'(acc0), 32'd4);
    chk("clr_ovf", 32'(ovf0), 32'd0);
    idle(1);

    // Reset mid-block
    cyc(0, 1, 8'd50, 0, 1);
    cyc(0, 1, 8'd50, 0, 1);
    cyc(0, 1, 8'd50, 0, 1);
    cyc(1, 1, 8'd50, 0, 1);
    chk("rst_mid_acc", 32'(acc0), 32'd0);
    block4(8'd2, 8'd2, 8'd2, 8'd2, 1);
    chk("rst_mid_res", 32'(acc0), 32'd8);
    idle(1);

    // COUNT=1 instance from a fresh reset
    cyc(1, 0, 8'd0, 0, 1);
    cyc(0, 1, 8'd7, 0, 1);
    chk("c1_acc7",   32'(acc1),       32'd7);
    chk("c1_valid7", 32'(out_valid1), 32'd1);
    chk("c1_ovf7",   32'(ovf1),       32'd0);
    cyc(0, 1, 8'd255, 0, 1);
    cyc(0, 1, 8'd255, 0, 1);
    chk("c1_acc255", 32'(acc1), 32'd255);
    chk("c1_ovf255", 32'(ovf1), 32'd0);
    idle(1);
    idle(1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
